// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg: shared state encoding and default widths for pipeline stage registers
package pipe_stage_pkg;

    // Default payload and stall-counter widths for stage instances
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_CNT_W  = 16;

    // Occupancy of a stage: no beat, main register live, main and skid registers live
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // A stage can take a new beat unless both of its registers are occupied
    function automatic logic can_accept(input pipe_state_t s);
        return s != FULL;
    endfunction

    // A stage presents a beat whenever its main register is occupied
    function automatic logic has_beat(input pipe_state_t s);
        return s != EMPTY;
    endfunction

endpackage

// File: rtl/pipe_stage_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count up on inc, hold once every bit is set so the value never wraps
    always_comb begin
        cnt_d = clear ? '0 : (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    // Clear has priority over counting
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: valid/ready pipeline register with skid buffer, flush and stall counter
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state_q;
    pipe_state_t       state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              in_hs;
    logic              out_hs;

    // Handshake flags come only from registered state, so ready never depends on out_ready
    assign in_ready  = can_accept(state_q);
    assign out_valid = has_beat(state_q);
    assign out_data  = main_q;
    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    // Next occupancy and payload; flush drops every held and incoming beat but leaves payload bits untouched
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                state_d = in_hs ? BUSY : EMPTY;
                main_d  = in_hs ? in_data : main_q;
            end
            BUSY: begin
                state_d = (in_hs && !out_hs) ? FULL : (!in_hs && out_hs) ? EMPTY : BUSY;
                main_d  = (in_hs && out_hs) ? in_data : main_q;
                skid_d  = (in_hs && !out_hs) ? in_data : skid_q;
            end
            FULL: begin
                state_d = out_hs ? BUSY : FULL;
                main_d  = out_hs ? skid_q : main_q;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    // State and payload registers; reset also zeroes both payload registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall (
        .clk  (clk),
        .clear(reset),
        .inc  (out_valid & ~out_ready & ~flush),
        .cnt  (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed vector table plus saturation sequence for pipe_stage
module tb_pipe_stage;

    typedef struct {
        string       nm;
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        eir;
        logic        eov;
        logic [31:0] eod;
        logic [3:0]  esc;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  stall_cnt;
    int          errors = 0;
    int          checks = 0;
    vec_t        v[$];

    always #5 clk = ~clk;

    pipe_stage #(
        .DATA_W(32),
        .CNT_W (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] d, input logic o);
        @(negedge clk);
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = o;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string nm, input logic ir, input logic ov, input logic [31:0] od, input logic [3:0] sc);
        chk({nm, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
        chk({nm, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({nm, ".out_data"}, out_data, od);
        chk({nm, ".stall_cnt"}, {28'd0, stall_cnt}, {28'd0, sc});
    endtask

    initial begin
        v.push_back('{"reset",      1, 0, 0, 32'h00, 1, 1, 0, 32'h00, 0});
        v.push_back('{"idle",       0, 0, 0, 32'h00, 1, 1, 0, 32'h00, 0});
        v.push_back('{"single_in",  0, 0, 1, 32'hAA, 1, 1, 1, 32'hAA, 0});
        v.push_back('{"single_out", 0, 0, 0, 32'h00, 1, 1, 0, 32'hAA, 0});
        for (int k = 1; k <= 8; k++)
            v.push_back('{$sformatf("stream%0d", k), 0, 0, 1, k, 1, 1, 1, k, 0});
        v.push_back('{"stream_end", 0, 0, 0, 32'h00, 1, 1, 0, 32'h08, 0});
        v.push_back('{"skid_a",     0, 0, 1, 32'h11, 0, 1, 1, 32'h11, 0});
        v.push_back('{"skid_b",     0, 0, 1, 32'h22, 0, 0, 1, 32'h11, 1});
        v.push_back('{"skid_hold",  0, 0, 0, 32'h00, 0, 0, 1, 32'h11, 2});
        v.push_back('{"skid_drain1",0, 0, 0, 32'h00, 1, 1, 1, 32'h22, 2});
        v.push_back('{"skid_drain2",0, 0, 0, 32'h00, 1, 1, 0, 32'h22, 2});
        v.push_back('{"fl_fill_a",  0, 0, 1, 32'h55, 0, 1, 1, 32'h55, 2});
        v.push_back('{"fl_fill_b",  0, 0, 1, 32'h66, 0, 0, 1, 32'h55, 3});
        v.push_back('{"fl_full",    0, 1, 1, 32'h33, 0, 1, 0, 32'h55, 3});
        v.push_back('{"fl_busy_ld", 0, 0, 1, 32'h77, 0, 1, 1, 32'h77, 3});
        v.push_back('{"fl_collide", 0, 1, 1, 32'h33, 1, 1, 0, 32'h77, 3});
        v.push_back('{"fl_after",   0, 0, 0, 32'h00, 1, 1, 0, 32'h77, 3});
        v.push_back('{"rst_fill_a", 0, 0, 1, 32'h88, 0, 1, 1, 32'h88, 3});
        v.push_back('{"rst_fill_b", 0, 0, 1, 32'h99, 0, 0, 1, 32'h88, 4});
        v.push_back('{"rst_mid",    1, 1, 0, 32'h00, 0, 1, 0, 32'h00, 0});
        v.push_back('{"rst_next",   0, 0, 1, 32'h44, 0, 1, 1, 32'h44, 0});
        v.push_back('{"rst_drain",  0, 0, 0, 32'h00, 1, 1, 0, 32'h44, 0});
        foreach (v[i]) begin
            drive(v[i].rst, v[i].fl, v[i].iv, v[i].d, v[i].ordy);
            expect_all(v[i].nm, v[i].eir, v[i].eov, v[i].eod, v[i].esc);
        end
        drive(0, 0, 1, 32'h5A, 0);
        expect_all("sat_load", 1, 1, 32'h5A, 0);
        for (int i = 1; i <= 20; i++) begin
            drive(0, 0, 0, 32'h00, 0);
            expect_all($sformatf("sat%0d", i), 1, 1, 32'h5A, (i > 15) ? 4'd15 : i[3:0]);
        end
        drive(1, 0, 0, 32'h00, 0);
        expect_all("sat_reset", 1, 0, 32'h00, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
